snake_input_ctrl: RTL and testbench
===================================

# snake_input_ctrl

Upstream control stage for the `snake` graphics block. It conditions the four raw pushbuttons (k0–k3) and the pause switch, then turns key presses into a registered snake heading. It also divides the VGA frame rate into a one-cycle `step` pulse that tells `snake` when to advance one cell. All outputs are in the `clk50` domain; `vert_sync` comes from `vga_sync` and is treated as asynchronous.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable `clk50` cycles required before a key level change is accepted (10 ms at 50 MHz).
- `FRAMES_PER_STEP`, default 6: number of frames per `step` pulse; legal range 1–255.

- `clk50`  in  1  50 MHz system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset (SW0).
- `k0`  in  1  raw key, active-low, RIGHT.
- `k1`  in  1  raw key, active-low, DOWN.
- `k2`  in  1  raw key, active-low, UP.
- `k3`  in  1  raw key, active-low, LEFT.
- `pause`  in  1  raw switch (SW1); 1 = paused.
- `vert_sync`  in  1  vertical sync from `vga_sync`, active-low pulse.
- `dir`  out  2  committed heading: UP=00, DOWN=01, LEFT=10, RIGHT=11.
- `step`  out  1  one-cycle pulse; `snake` advances one cell.
- `turned`  out  1  one-cycle pulse, coincident with `step`, when `dir` changed on that step.

## Operation
- **Input synchronisation.** Each key, `pause` and `vert_sync` passes through a 2-flop synchroniser.
- **Debounce.** Each key has its own counter.
  - The counter increments while the synced level differs from the accepted level, and clears otherwise.
  - When it reaches `DEBOUNCE_CYCLES`, the accepted level takes the synced value.
  - An accepted 1→0 transition produces a one-cycle `press` pulse.
- **Frame tick.** A rising edge of synced `vert_sync` (end of the sync pulse) produces a one-cycle `frame` pulse.
- **Step counter.** An 8-bit frame counter runs 0..`FRAMES_PER_STEP`-1.
  - On `frame`, when not paused: if the count equals `FRAMES_PER_STEP`-1, it wraps to 0 and `step` fires on the following cycle; otherwise it increments.
  - While paused, the counter holds, `step` never fires, and `press` pulses are discarded.
- **Heading registers.** Two registers hold the heading: `cur_dir` (drives `dir`) and `next_dir` (pending).
  - On a `step` cycle, `cur_dir` ← `next_dir`, and `turned` = (`next_dir` ≠ `cur_dir`).
  - A `press` for direction d is compared against the reference heading. The reference is `cur_dir`, or `next_dir` if `step` is asserted in the same cycle.
  - If d is the reverse of the reference (same bit1, opposite bit0), the press is ignored. Otherwise `next_dir` ← d, and the last press before a step wins.
  - Simultaneous presses in one cycle resolve by priority k2 > k1 > k3 > k0, and only the winner is evaluated.
- **Reset** (asynchronous, any time, including mid-debounce or mid-step):
  - `cur_dir` = `next_dir` = RIGHT; `step` = 0; `turned` = 0.
  - Frame counter = 0; debounce counters = 0; accepted key levels = 1 (released); synchronisers = 1.

## Timing
- Key latency: a clean, bounce-free pin falling edge gives `press` exactly `DEBOUNCE_CYCLES`+3 cycles later (2 synchroniser cycles, the accept cycle, then the pulse register). `next_dir` updates on the cycle after `press`.
- Bounce: any return to the old level before the count completes clears the counter and produces no pulse.
- Frame latency: the `vert_sync` rising edge at the pin gives `frame` 3 cycles later, and `step` 1 cycle after the wrapping `frame`.
- `dir` changes only in the cycle where `step` is high, so it is stable for all other cycles.
- `step` and `turned` are registered and never wider than one cycle. The minimum spacing between steps is one frame.

## Configuration
- `SNAKE_TURBO_EN` defined: while the accepted level of the key matching `cur_dir` is held down, the wrap threshold becomes max(1, `FRAMES_PER_STEP`/2). The counter is compared against the new threshold immediately; if it already exceeds the threshold, it wraps on the next `frame`.
- Not defined: the threshold is always `FRAMES_PER_STEP`, and the held-key logic is absent.

## Structure
- Package `snake_pkg`:
  - `dir_t` (2-bit enum UP/DOWN/LEFT/RIGHT);
  - `DIR_RESET` = RIGHT;
  - function `is_reverse(a, b)`.
  - `snake` imports the same package for `dir`.
- Sub-module `key_debounce` (synchroniser, counter, accepted level, `press` pulse), parameterised by `DEBOUNCE_CYCLES`, instantiated four times.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `FRAMES_PER_STEP`=3.
- Reset, then 3 `vert_sync` pulses with no keys → `step` once on the cycle after the 3rd `frame`; `dir`=11, `turned`=0.
- k2 held low 10 cycles → `press` exactly 7 cycles after the edge; the next `step` gives `dir`=00 and `turned`=1.
- `dir`=RIGHT, press k3 (LEFT) → ignored, and the next step keeps `dir`=11 with `turned`=0. Then press k2 followed by k3 before the step → `dir`=00 after the step.
- k1 toggling low/high every 3 cycles for 30 cycles → no `press` and no `next_dir` change.
- `pause`=1 across 6 frames while pressing k1 → no `step`, and `dir` unchanged. Release `pause` → first step after 3 more frames, `dir`=11.
- Assert `reset` mid-debounce, one frame before a wrap, with `next_dir`=DOWN → all outputs reset; the first step after release occurs 3 frames later with `dir`=11.

Source files
------------

// File: rtl/snake_input_ctrl_pkg.sv
// Shared heading encoding and turn rules for the snake input path and the snake renderer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Key slot of each raw button: k0 RIGHT, k1 DOWN, k2 UP, k3 LEFT.
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  // Reverse heading shares the axis bit and flips the sense bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  // Simultaneous presses resolve k2 > k1 > k3 > k0.
  function automatic dir_t pick_press(input logic [3:0] press);
    dir_t d;
    if (press[KEY_UP])        d = DIR_UP;
    else if (press[KEY_DOWN]) d = DIR_DOWN;
    else if (press[KEY_LEFT]) d = DIR_LEFT;
    else                      d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// Board-side bundle of snake_input_ctrl: raw buttons/switch/vsync in, heading and step strobes out.
interface snake_input_ctrl_if;
  import snake_pkg::*;

  logic       k0;
  logic       k1;
  logic       k2;
  logic       k3;
  logic       pause;
  logic       vert_sync;

  // No valid/ready: step and turned are single-cycle strobes the consumer must
  // act on in the cycle they are high; dir is stable whenever step is low.
  dir_t       dir;
  logic       step;
  logic       turned;

  // Observation taps: pending heading, per-key press pulses, accepted held keys.
  dir_t       next_dir;
  logic [3:0] press;
  logic [3:0] held;

  modport master (
    output k0, k1, k2, k3, pause, vert_sync,
    input  dir, step, turned, next_dir, press, held
  );

  modport slave (
    input  k0, k1, k2, k3, pause, vert_sync,
    output dir, step, turned, next_dir, press, held
  );
endinterface

// File: rtl/snake_input_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter, accepted level and a press pulse on 1->0.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample;
  // press is registered from the accepted-level history, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/snake_input_ctrl.sv
// Key conditioning, frame-rate step divider and heading registers for snake.
// Optional SNAKE_TURBO_EN: holding the key of the current heading halves the step period.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic               clk50,
  input  logic               reset,
  snake_input_ctrl_if.slave  bus
);

  localparam logic [7:0] THR_FULL = 8'(FRAMES_PER_STEP);

  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic [3:0] key_press;

  logic       pause_s1, pause_s2;
  logic       vs_s1, vs_s2, vs_d;
  logic       frame;

  logic [7:0] frame_cnt;
  logic [7:0] thr;
  logic       step;
  logic       turned;
  dir_t       cur_dir;
  dir_t       next_dir;

  logic       paused;
  logic       wrap;
  logic       step_now;
  dir_t       ref_dir;
  dir_t       press_dir;
  logic       take_press;

  assign key_raw = {bus.k3, bus.k2, bus.k1, bus.k0};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (clk50),
      .rst  (reset),
      .key  (key_raw[i]),
      .level(key_level[i]),
      .press(key_press[i])
    );
  end

  // Frame pulse marks the end of the (active-low) vsync pulse.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      pause_s1 <= 1'b1;
      pause_s2 <= 1'b1;
      vs_s1    <= 1'b1;
      vs_s2    <= 1'b1;
      vs_d     <= 1'b1;
      frame    <= 1'b0;
    end else begin
      pause_s1 <= bus.pause;
      pause_s2 <= pause_s1;
      vs_s1    <= bus.vert_sync;
      vs_s2    <= vs_s1;
      vs_d     <= vs_s2;
      frame    <= vs_s2 & ~vs_d;
    end
  end

  assign paused = pause_s2;

`ifdef SNAKE_TURBO_EN
  localparam int         THR_HALF = FRAMES_PER_STEP / 2;
  localparam logic [7:0] THR_FAST = 8'((THR_HALF < 1) ? 1 : THR_HALF);

  logic held_cur;

  always_comb begin
    held_cur = 1'b0;
    case (cur_dir)
      DIR_UP:    held_cur = ~key_level[KEY_UP];
      DIR_DOWN:  held_cur = ~key_level[KEY_DOWN];
      DIR_LEFT:  held_cur = ~key_level[KEY_LEFT];
      default:   held_cur = ~key_level[KEY_RIGHT];
    endcase
  end

  assign thr = held_cur ? THR_FAST : THR_FULL;
`else
  assign thr = THR_FULL;
`endif

  // ">=" lets a counter left above a freshly lowered threshold wrap on the next frame.
  always_comb begin
    wrap       = (frame_cnt >= (thr - 8'd1));
    step_now   = frame & ~paused & wrap;
    ref_dir    = step_now ? next_dir : cur_dir;
    press_dir  = pick_press(key_press);
    take_press = (|key_press) & ~paused & ~is_reverse(press_dir, ref_dir);
  end

  // cur_dir updates on the same edge that raises step, so dir only moves while step is high.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      step      <= 1'b0;
      turned    <= 1'b0;
      cur_dir   <= DIR_RESET;
      next_dir  <= DIR_RESET;
    end else begin
      step   <= step_now;
      turned <= step_now && (next_dir != cur_dir);
      if (step_now) begin
        frame_cnt <= '0;
        cur_dir   <= next_dir;
      end else if (frame && !paused) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (take_press) begin
        next_dir <= press_dir;
      end
    end
  end

  assign bus.dir      = cur_dir;
  assign bus.step     = step;
  assign bus.turned   = turned;
  assign bus.next_dir = next_dir;
  assign bus.press    = key_press;
  assign bus.held     = ~key_level;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=3.
module tb_snake_input_ctrl;

  typedef struct {
    logic [3:0] keys;
    logic [1:0] exp_dir;
    logic       exp_turned;
  } vec_t;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   mon_err = 0;
  int   press_seen = 0;
  logic       prev_step = 1'b0;
  logic [1:0] prev_dir = 2'b11;
  vec_t vecs[9];

  snake_input_ctrl_if bus ();

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(3)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clk50 = ~clk50;

  // Invariants: step one cycle wide, turned only with step, dir moves only with step.
  always @(negedge clk50) begin
    if (reset) begin
      prev_step = 1'b0;
      prev_dir  = bus.dir;
    end else begin
      if (bus.turned && !bus.step) mon_err++;
      if (bus.step && prev_step) mon_err++;
      if ((bus.dir != prev_dir) && !bus.step) mon_err++;
      if (|bus.press) press_seen++;
      prev_step = bus.step;
      prev_dir  = bus.dir;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    @(negedge clk50);
  endtask

  task automatic vsync_pulse(output int step_at, output logic [1:0] sdir, output logic sturn);
    step_at = 0;
    sdir    = 2'b00;
    sturn   = 1'b0;
    bus.vert_sync = 1'b0;
    tick(3);
    bus.vert_sync = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (bus.step && step_at == 0) begin
        step_at = k;
        sdir    = bus.dir;
        sturn   = bus.turned;
      end
    end
  endtask

  task automatic do_step(input string name, input logic [1:0] exp_dir, input logic exp_turned);
    int a1, a2, a3;
    logic [1:0] d;
    logic t;
    vsync_pulse(a1, d, t);
    vsync_pulse(a2, d, t);
    vsync_pulse(a3, d, t);
    check({name, "_early"}, a1 + a2, 0);
    check({name, "_at"}, a3, 4);
    check({name, "_dir"}, d, exp_dir);
    check({name, "_turned"}, t, exp_turned);
  endtask

  task automatic press_keys(input logic [3:0] mask);
    bus.k0 = ~mask[0];
    bus.k1 = ~mask[1];
    bus.k2 = ~mask[2];
    bus.k3 = ~mask[3];
    tick(8);
    bus.k0 = 1'b1;
    bus.k1 = 1'b1;
    bus.k2 = 1'b1;
    bus.k3 = 1'b1;
    tick(10);
  endtask

  initial begin
    int p_at, p_before, sum;
    logic [1:0] nd7, nd8, d;
    logic t;
    int a;

    vecs[0] = '{4'b1000, 2'b10, 1'b1};  // LEFT from UP
    vecs[1] = '{4'b0001, 2'b10, 1'b0};  // RIGHT reverses LEFT: ignored
    vecs[2] = '{4'b0010, 2'b01, 1'b1};  // DOWN
    vecs[3] = '{4'b0100, 2'b01, 1'b0};  // UP reverses DOWN: ignored
    vecs[4] = '{4'b1111, 2'b01, 1'b0};  // all keys: UP wins, still reverse
    vecs[5] = '{4'b1001, 2'b10, 1'b1};  // k3+k0: LEFT wins
    vecs[6] = '{4'b0011, 2'b01, 1'b1};  // k1+k0: DOWN wins
    vecs[7] = '{4'b0001, 2'b11, 1'b1};  // RIGHT
    vecs[8] = '{4'b1000, 2'b11, 1'b0};  // LEFT reverses RIGHT: ignored

    bus.k0 = 1'b1;
    bus.k1 = 1'b1;
    bus.k2 = 1'b1;
    bus.k3 = 1'b1;
    bus.pause = 1'b0;
    bus.vert_sync = 1'b1;

    // Reset state
    tick(3);
    check("rst_dir", bus.dir, 2'b11);
    check("rst_next_dir", bus.next_dir, 2'b11);
    check("rst_step", bus.step, 1'b0);
    check("rst_turned", bus.turned, 1'b0);
    check("rst_press", bus.press, 4'b0000);
    reset = 1'b0;
    tick(4);

    // Three frames with no keys
    do_step("idle", 2'b11, 1'b0);

    // k2 press latency and next_dir update timing
    p_at = 0;
    nd7 = 2'b00;
    nd8 = 2'b11;
    p_before = press_seen;
    bus.k2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (bus.press[2] && p_at == 0) p_at = k;
      if (k == 7) nd7 = bus.next_dir;
      if (k == 8) nd8 = bus.next_dir;
    end
    bus.k2 = 1'b1;
    tick(10);
    check("press_latency", p_at, 7);
    check("press_count", press_seen - p_before, 1);
    check("next_dir_on_press", nd7, 2'b11);
    check("next_dir_after_press", nd8, 2'b00);
    do_step("up", 2'b00, 1'b1);

    // Table: press pattern, then one full step
    for (int i = 0; i < 9; i++) begin
      press_keys(vecs[i].keys);
      check($sformatf("vec%0d_next", i), bus.next_dir, vecs[i].exp_dir);
      do_step($sformatf("vec%0d", i), vecs[i].exp_dir, vecs[i].exp_turned);
    end

    // Bouncing k1: never held long enough
    p_before = press_seen;
    for (int i = 0; i < 5; i++) begin
      bus.k1 = 1'b0;
      tick(3);
      bus.k1 = 1'b1;
      tick(3);
    end
    tick(10);
    check("bounce_press", press_seen - p_before, 0);
    check("bounce_next_dir", bus.next_dir, 2'b11);

    // Pause: frames and presses ignored
    bus.pause = 1'b1;
    tick(4);
    press_keys(4'b0010);
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      vsync_pulse(a, d, t);
      sum += a;
    end
    check("pause_no_step", sum, 0);
    check("pause_dir", bus.dir, 2'b11);
    check("pause_next_dir", bus.next_dir, 2'b11);
    bus.pause = 1'b0;
    tick(4);
    do_step("unpause", 2'b11, 1'b0);

    // UP then LEFT before the step: LEFT judged against RIGHT and dropped
    press_keys(4'b0100);
    check("seq_up_next", bus.next_dir, 2'b00);
    press_keys(4'b1000);
    check("seq_left_next", bus.next_dir, 2'b00);
    do_step("seq", 2'b00, 1'b1);

    // Reset mid-debounce, one frame before a wrap, with DOWN pending
    press_keys(4'b0001);
    do_step("pre_rst", 2'b11, 1'b1);
    press_keys(4'b0010);
    check("pre_rst_next", bus.next_dir, 2'b01);
    vsync_pulse(a, d, t);
    sum = a;
    vsync_pulse(a, d, t);
    sum += a;
    check("pre_rst_no_step", sum, 0);
    bus.k2 = 1'b0;
    tick(4);
    reset = 1'b1;
    bus.k2 = 1'b1;
    tick(1);
    check("mid_rst_dir", bus.dir, 2'b11);
    check("mid_rst_next_dir", bus.next_dir, 2'b11);
    check("mid_rst_step", bus.step, 1'b0);
    check("mid_rst_turned", bus.turned, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(4);
    do_step("post_rst", 2'b11, 1'b0);
    check("post_rst_next_dir", bus.next_dir, 2'b11);

    check("monitor_invariants", mon_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
